// File: rtl/exu_div_sched.sv
// exu_div_sched
// Scheduler for the shared multi-cycle divider in the execute unit. Divide
// requests from issue enter a small in-order circular queue. They run one at a
// time on the single divider, and each result waits in a one-entry buffer until
// the register-file write port has no ALU traffic.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid_i/req_ready_o    request handshake from issue
//   req_op_i, req_dividend_i,
//   req_divisor_i, req_waddr_i request payload
//   flush_i                    interrupt flush: drop queued and in-flight work
//   div_start_o                divider start, held high for the whole operation
//   div_dividend_o, div_divisor_o, div_op_o, div_reg_waddr_o
//                              head-entry operands presented to the divider
//   div_ready_i, div_result_i  divider completion and result
//   alu_wb_i                   ALU/AGU/CSR owns the write port this cycle
//   wb_valid_o, wb_data_o, wb_waddr_o
//                              divide writeback to the register file
//   raw_chk_addr_i/raw_hit_o   pending-destination hazard check for issue
//   busy_o                     any queued, in-flight or buffered work
module exu_div_sched #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    req_op_i,
  input  logic [DW-1:0] req_dividend_i,
  input  logic [DW-1:0] req_divisor_i,
  input  logic [AW-1:0] req_waddr_i,
  input  logic          flush_i,
  output logic          div_start_o,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  output logic [2:0]    div_op_o,
  output logic [AW-1:0] div_reg_waddr_o,
  input  logic          div_ready_i,
  input  logic [DW-1:0] div_result_i,
  input  logic          alu_wb_i,
  output logic          wb_valid_o,
  output logic [DW-1:0] wb_data_o,
  output logic [AW-1:0] wb_waddr_o,
  input  logic [AW-1:0] raw_chk_addr_i,
  output logic          raw_hit_o,
  output logic          busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Queue storage. Slots are never reset. Validity comes only from the
  // pointers and the count.
  logic [2:0]    op_mem       [DEPTH];
  logic [DW-1:0] dividend_mem [DEPTH];
  logic [DW-1:0] divisor_mem  [DEPTH];
  logic [AW-1:0] waddr_mem    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic [AW-1:0] buf_waddr_q, buf_waddr_d;

  logic full, empty, push, pop, in_run, in_wb, wb_fire;
  logic [DEPTH-1:0] entry_hit;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  // Readiness ignores a pop in the same cycle. A full queue refuses pushes
  // even while the head retires.
  assign req_ready_o = !full && !flush_i;
  assign push        = req_valid_i && req_ready_o;
  assign in_run      = (state_q == ST_RUN);
  assign in_wb       = (state_q == ST_WB);
  assign pop         = in_run && div_ready_i && !flush_i;
  // The buffer drains when the port is free. A result for x0 drains silently.
  assign wb_fire     = in_wb && !alu_wb_i;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]       <= req_op_i;
      dividend_mem[wr_ptr_q] <= req_dividend_i;
      divisor_mem[wr_ptr_q]  <= req_divisor_i;
      waddr_mem[wr_ptr_q]    <= req_waddr_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // count_d already includes this cycle's push. This lets IDLE launch one
  // cycle after the push, and lets WB chain straight into RUN.
  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_waddr_d = buf_waddr_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          state_d     = ST_WB;
          buf_data_d  = div_result_i;
          buf_waddr_d = waddr_mem[rd_ptr_q];
        end
      end
      ST_WB: begin
        if (wb_fire) state_d = (count_d != '0) ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      buf_data_q  <= '0;
      buf_waddr_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_waddr_q <= buf_waddr_d;
    end
  end

  // Flush removes start in the same cycle, so the divider can abandon the
  // operation at once.
  assign div_start_o     = in_run && !flush_i;
  assign div_dividend_o  = in_run ? dividend_mem[rd_ptr_q] : '0;
  assign div_divisor_o   = in_run ? divisor_mem[rd_ptr_q]  : '0;
  assign div_op_o        = in_run ? op_mem[rd_ptr_q]       : 3'd0;
  assign div_reg_waddr_o = in_run ? waddr_mem[rd_ptr_q]    : '0;

  assign wb_valid_o = wb_fire && (buf_waddr_q != '0);
  assign wb_data_o  = buf_data_q;
  assign wb_waddr_o = buf_waddr_q;

  // A slot is live when its distance from the head is below the count.
  // The RUN head is still a live queue entry, so it is covered here.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PW-1:0] offs;
    assign offs          = PW'(gi) - rd_ptr_q;
    assign entry_hit[gi] = (CW'(offs) < count_q) && (waddr_mem[gi] == raw_chk_addr_i);
  end

  assign raw_hit_o = (raw_chk_addr_i != '0) &&
                     ((|entry_hit) || (in_wb && (buf_waddr_q == raw_chk_addr_i)));

  assign busy_o = !empty || (state_q != ST_IDLE);

endmodule
